// File: rtl/mux_pkg.sv
// Shared datapath constants and helpers for the N:1 pipelined mux.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mux_pkg;

  // Datapath width defaults
  localparam int MUX_WIDTH_DEF  = 32;
  localparam int MUX_NUM_IN_DEF = 4;
  localparam int MUX_NUM_IN_MIN = 2;
  localparam int MUX_NUM_IN_MAX = 16;

  // Select width: at least one bit even for a 2-input mux
  function automatic int sel_width(input int num_in);
    return (num_in <= 2) ? 1 : $clog2(num_in);
  endfunction

endpackage

// File: rtl/skid_buf.sv
// One-entry skid register in front of a registered output stage.
// Latency: 1 cycle when the output stage is free; the skid entry adds one cycle under stall.
// Backpressure: in_rdy_o = !skid valid, registered, so there is no comb path from out_rdy_i.
module skid_buf #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_vld_i,
  output logic             in_rdy_o,
  input  logic [WIDTH-1:0] in_dat_i,
  output logic             out_vld_o,
  input  logic             out_rdy_i,
  output logic [WIDTH-1:0] out_dat_o
);

  logic             out_vld_q, out_vld_d;
  logic [WIDTH-1:0] out_dat_q, out_dat_d;
  logic             skid_vld_q, skid_vld_d;
  logic [WIDTH-1:0] skid_dat_q, skid_dat_d;
  logic             in_fire;
  logic             out_free;

  assign in_rdy_o = !skid_vld_q;
  assign in_fire  = in_vld_i & in_rdy_o;
  assign out_free = !out_vld_q | out_rdy_i;

  // Next state: drain skid first, otherwise load output directly or park in skid when stalled
  always_comb begin
    out_vld_d  = out_vld_q;
    out_dat_d  = out_dat_q;
    skid_vld_d = skid_vld_q;
    skid_dat_d = skid_dat_q;
    if (out_free) begin
      if (skid_vld_q) begin
        out_dat_d  = skid_dat_q;
        out_vld_d  = 1'b1;
        skid_vld_d = 1'b0;
      end else begin
        out_vld_d = in_fire;
        if (in_fire) begin
          out_dat_d = in_dat_i;
        end
      end
    end else if (in_fire) begin
      skid_dat_d = in_dat_i;
      skid_vld_d = 1'b1;
    end
  end

  // State registers; reset empties both entries and zeroes their data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q  <= 1'b0;
      out_dat_q  <= '0;
      skid_vld_q <= 1'b0;
      skid_dat_q <= '0;
    end else begin
      out_vld_q  <= out_vld_d;
      out_dat_q  <= out_dat_d;
      skid_vld_q <= skid_vld_d;
      skid_dat_q <= skid_dat_d;
    end
  end

  assign out_vld_o = out_vld_q;
  assign out_dat_o = out_dat_q;

endmodule

// File: rtl/mux_nx1_pipe.sv
// N:1 mux with registered valid/ready output; out-of-range select yields zero data.
// Latency: 1 cycle from accepted input to out_data when the output stage is free.
// Backpressure: one-entry skid absorbs a stall; in_ready drops only while the skid is full. Optional sticky sel_err under MUX_SEL_CHECK_EN.
module mux_nx1_pipe import mux_pkg::*; #(
  parameter  int WIDTH  = MUX_WIDTH_DEF,
  parameter  int NUM_IN = MUX_NUM_IN_DEF,
  localparam int SEL_W  = sel_width(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err
);

  logic [WIDTH-1:0] sel_word;

  // Channel select; an index with no matching channel leaves the word at zero
  always_comb begin
    sel_word = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        sel_word = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  skid_buf #(
    .WIDTH (WIDTH)
  ) u_skid_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_vld_i  (in_valid),
    .in_rdy_o  (in_ready),
    .in_dat_i  (sel_word),
    .out_vld_o (out_valid),
    .out_rdy_i (out_ready),
    .out_dat_o (out_data)
  );

`ifdef MUX_SEL_CHECK_EN
  localparam logic [SEL_W:0] NUM_IN_L = (SEL_W+1)'(NUM_IN);

  logic in_fire;
  logic sel_oob;
  logic sel_err_q, sel_err_d;

  assign in_fire = in_valid & in_ready;
  assign sel_oob = ({1'b0, sel} >= NUM_IN_L);

  // Sticky flag: any accepted out-of-range select latches until reset
  always_comb begin
    sel_err_d = sel_err_q | (in_fire & sel_oob);
  end

  // Flag register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= sel_err_d;
    end
  end

  assign sel_err = sel_err_q;
`else
  assign sel_err = 1'b0;
`endif

endmodule

// File: doc/mux_nx1_pipe.md
MUX_NX1_PIPE -- requirements
Module: mux_nx1_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning data width in bits of each input and of the output.
REQ-002 The block SHALL have parameter NUM_IN, default 4, meaning number of input channels, legal range 2..16.
REQ-003 The block SHALL derive localparam SEL_W = max(1, clog2(NUM_IN)) for the select width; it is not overridable.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port in_data, input, NUM_IN*WIDTH bits: flattened channels; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-007 The block SHALL have port sel, input, SEL_W bits: channel index, sampled with in_data on input transfer.
REQ-008 The block SHALL have port in_valid, input, 1 bit: upstream offers in_data/sel.
REQ-009 The block SHALL have port in_ready, output, 1 bit: block accepts input this cycle.
REQ-010 The block SHALL have port out_data, output, WIDTH bits: selected, registered word.
REQ-011 The block SHALL have port out_valid, output, 1 bit: out_data holds an unconsumed word.
REQ-012 The block SHALL have port out_ready, input, 1 bit: downstream consumes out_data this cycle.
REQ-013 The block SHALL have port sel_err, output, 1 bit: sticky out-of-range select flag (only with MUX_SEL_CHECK_EN).

Function
REQ-014 The block SHALL register all outputs; there SHALL be no combinational path from in_* to out_* or from out_ready to in_ready.
REQ-015 The block SHALL define in_fire = in_valid & in_ready and out_fire = out_valid & out_ready.
REQ-016 The block SHALL deliver the word selected by an accepted input on out_data with a latency of 1 cycle when the output stage is free, and sustain one transfer per cycle.
REQ-017 The block SHALL select channel sel on input transfer; if sel >= NUM_IN, it SHALL select all-zero data.
REQ-018 The block SHALL contain a one-entry skid register (skid_data, skid_valid) and drive in_ready = !skid_valid.
REQ-019 Output stage free (!out_valid or out_ready): if skid_valid, the block SHALL move skid_data to out_data, clear skid_valid and set out_valid; else out_valid <= in_fire and, on in_fire, out_data <= selected word.
REQ-020 Output stage stalled (out_valid and !out_ready): out_data SHALL hold; on in_fire, the block SHALL write the selected word to skid_data and set skid_valid.
REQ-021 The block SHALL never drop, duplicate or reorder accepted words; order out equals order in.
REQ-022 While out_valid is high and out_ready is low, out_data SHALL remain stable.
REQ-023 Changes on sel or in_data while in_valid is low SHALL have no effect on state.

Reset
REQ-024 Asserting rst_n low SHALL immediately clear out_valid, skid_valid and sel_err, zero out_data and skid_data, and force in_ready to 1, irrespective of clk.
REQ-025 Reset mid-transfer SHALL discard the buffered words; the first cycle after deassertion SHALL accept input normally.

Configuration
REQ-026 With macro MUX_SEL_CHECK_EN defined, sel_err SHALL set on any in_fire with sel >= NUM_IN and stay set until reset.
REQ-027 Without MUX_SEL_CHECK_EN, the sel_err port SHALL be tied to 0 and no check logic SHALL be built; data behaviour (zero select) is unchanged.

Structure
REQ-028 Default WIDTH/NUM_IN constants SHALL reside in the shared package mux_pkg, next to the other datapath width constants.
REQ-029 The skid/output register pair SHALL be a sub-module named skid_buf (parameter WIDTH, valid/ready on both sides), instantiated once after the combinational select.

Verification
REQ-030 Reset: rst_n=0 mid-stream -> out_valid=0, in_ready=1, out_data=0 immediately; after release, first word passes with 1-cycle latency.
REQ-031 Streaming: NUM_IN=4, out_ready=1, in_valid=1, sel=0,1,2,3 with channel k = 32'hA000_000k -> out_data A0000000..A0000003 on consecutive cycles, no bubbles.
REQ-032 Backpressure: out_ready=0 for 3 cycles while sending sel=1 then sel=2 -> out holds word 1, skid holds word 2, in_ready=0 on cycle 2; out_ready=1 -> words 1,2 delivered in order, in_ready returns to 1.
REQ-033 Out-of-range: NUM_IN=3, sel=3 accepted -> out_data=0; with MUX_SEL_CHECK_EN sel_err=1 and remains 1; without it sel_err=0.
REQ-034 Random: NUM_IN=5, WIDTH=8, 10000 cycles random in_valid/out_ready/sel -> scoreboard matches all words, out_data stable under stall.
